// File: rtl/conv_mac_engine.sv
// Multi-channel convolution MAC: streams SIZE taps per window across CH channels, adds a shared
// bias, then emits raw accumulators plus requantised, saturated, optionally ReLU-clipped activations.
module conv_mac_engine #(
   parameter int unsigned CH    = 3,
   parameter int unsigned DW    = 16,
   parameter int unsigned FRAC  = 8,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned SZ_W  = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [SZ_W-1:0]     size,
   input  logic                relu_en,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*DW-1:0]    d_in,
   input  logic [CH*DW-1:0]    weight,
   input  logic [DW-1:0]       bias,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*ACC_W-1:0] acc_out,
   output logic [CH*DW-1:0]    act_out,
   output logic                busy
);

   typedef enum logic [1:0] {StIdle, StAcc, StBias, StOut} state_e;

   localparam logic signed [ACC_W-1:0] ActMax = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ActMin = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   state_e                  state_q, state_d;
   logic [SZ_W-1:0]         cnt_q, cnt_d;
   logic [SZ_W-1:0]         size_q, size_d;
   logic                    relu_q, relu_d;
   logic                    in_ready_q, out_valid_q, busy_q;
   logic signed [ACC_W-1:0] acc_q [CH];
   logic signed [ACC_W-1:0] acc_d [CH];
   logic [DW-1:0]           act_q [CH];
   logic [DW-1:0]           act_d [CH];
   logic signed [ACC_W-1:0] prod_ext [CH];
   logic signed [ACC_W-1:0] bias_sh;

   // Truncating shift back to Q(FRAC), clamp to the DW-bit signed range, then optional ReLU.
   function automatic logic [DW-1:0] requant(input logic signed [ACC_W-1:0] a,
                                             input logic relu);
      logic signed [ACC_W-1:0] t;
      logic [DW-1:0]           r;
      t = a >>> FRAC;
      if (t > ActMax) r = ActMax[DW-1:0];
      else if (t < ActMin) r = ActMin[DW-1:0];
      else r = t[DW-1:0];
      if (relu && r[DW-1]) r = '0;
      return r;
   endfunction

   assign bias_sh = ACC_W'($signed(bias)) <<< FRAC;

   for (genvar c = 0; c < CH; c++) begin : g_chan
      logic signed [2*DW-1:0] prod;
      assign prod = (2*DW)'($signed(d_in[c*DW +: DW])) * (2*DW)'($signed(weight[c*DW +: DW]));
      assign prod_ext[c] = ACC_W'(prod);
      assign acc_out[c*ACC_W +: ACC_W] = acc_q[c];
      assign act_out[c*DW +: DW]       = act_q[c];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      relu_d  = relu_q;
      acc_d   = acc_q;
      act_d   = act_q;
      if (clear) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en) begin
                  size_d  = size;
                  relu_d  = relu_en;
                  cnt_d   = '0;
                  for (int c = 0; c < CH; c++) acc_d[c] = '0;
                  state_d = (size == '0) ? StBias : StAcc;
               end
            end
            StAcc: begin
               if (in_valid) begin
                  for (int c = 0; c < CH; c++) acc_d[c] = acc_q[c] + prod_ext[c];
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == size_q) state_d = StBias;
               end
            end
            StBias: begin
               for (int c = 0; c < CH; c++) begin
                  acc_d[c] = acc_q[c] + bias_sh;
                  act_d[c] = requant(acc_d[c], relu_q);
               end
               state_d = StOut;
            end
            StOut: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Handshake/status flags are registered from the next state so no output is combinational.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         size_q      <= '0;
         relu_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            acc_q[c] <= '0;
            act_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         relu_q      <= relu_d;
         in_ready_q  <= (state_d == StAcc);
         out_valid_q <= (state_d == StOut);
         busy_q      <= (state_d != StIdle);
         for (int c = 0; c < CH; c++) begin
            acc_q[c] <= acc_d[c];
            act_q[c] <= act_d[c];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule
